// File: rtl/mem_lsu_stage.sv
// MIPS32 MEM stage: load/store over a req/ack data port with pipeline stall,
// lane alignment, sign/zero extension, alignment faults, LL/SC link bit and bus timeout.
module mem_lsu_stage #(
    parameter int REG_AW      = 5,
    parameter int TIMEOUT     = 15,
    parameter int BIG_ENDIAN  = 1,
    parameter int ALIGN_CHECK = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [REG_AW-1:0] wd_i,
    input  logic              wreg_i,
    input  logic [31:0]       wdata_i,
    input  logic              whilo_i,
    input  logic [31:0]       hi_i,
    input  logic [31:0]       lo_i,
    input  logic [3:0]        mem_op_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    input  logic              llbit_clr_i,
    output logic              dm_req_o,
    output logic              dm_we_o,
    output logic [31:0]       dm_addr_o,
    output logic [3:0]        dm_be_o,
    output logic [31:0]       dm_wdata_o,
    input  logic              dm_ack_i,
    input  logic [31:0]       dm_rdata_i,
    output logic              stall_req_o,
    output logic              valid_o,
    output logic [REG_AW-1:0] wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic              whilo_o,
    output logic [31:0]       hi_o,
    output logic [31:0]       lo_o,
    output logic              adel_o,
    output logic              ades_o,
    output logic              buserr_o,
    output logic [31:0]       badvaddr_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          llbit;

    logic        is_load, is_store, sz_b, sz_h, ld_sext, is_mem, is_ll, is_sc;
    logic        misalign, issue, tmo_hit, req, done, timeout, fire;
    logic [1:0]  lane_off, byte_lane;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_data, res;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sz_b     = 1'b0;
        sz_h     = 1'b0;
        ld_sext  = 1'b0;
        case (mem_op_i)
            4'd1:        begin is_load = 1'b1; sz_b = 1'b1; ld_sext = 1'b1; end
            4'd2:        begin is_load = 1'b1; sz_b = 1'b1; end
            4'd3:        begin is_load = 1'b1; sz_h = 1'b1; ld_sext = 1'b1; end
            4'd4:        begin is_load = 1'b1; sz_h = 1'b1; end
            4'd5, 4'd9:  is_load = 1'b1;
            4'd6:        begin is_store = 1'b1; sz_b = 1'b1; end
            4'd7:        begin is_store = 1'b1; sz_h = 1'b1; end
            4'd8, 4'd10: is_store = 1'b1;
            default:     ;
        endcase
    end

    assign is_mem = is_load | is_store;
    assign is_ll  = (mem_op_i == 4'd9);
    assign is_sc  = (mem_op_i == 4'd10);

    assign misalign = (ALIGN_CHECK != 0) &&
                      ((sz_h && mem_addr_i[0]) ||
                       (is_mem && !sz_b && !sz_h && (mem_addr_i[1:0] != 2'b00)));

    // Offset is force-aligned by access size; byte_lane is the physical byte slot.
    assign lane_off  = sz_b ? mem_addr_i[1:0] : (sz_h ? {mem_addr_i[1], 1'b0} : 2'b00);
    assign byte_lane = (BIG_ENDIAN != 0) ? ~lane_off : lane_off;

    assign ld_b = dm_rdata_i[{byte_lane, 3'b000} +: 8];
    assign ld_h = dm_rdata_i[{byte_lane[1], 4'b0000} +: 16];

    always_comb begin
        ld_data = dm_rdata_i;
        if (sz_b)      ld_data = ld_sext ? {{24{ld_b[7]}}, ld_b} : {24'b0, ld_b};
        else if (sz_h) ld_data = ld_sext ? {{16{ld_h[15]}}, ld_h} : {16'b0, ld_h};
        res = ld_data;
        if (is_sc)         res = 32'd1;
        else if (is_store) res = wdata_i;
    end

    assign dm_addr_o = {mem_addr_i[31:2], 2'b00};

    always_comb begin
        dm_be_o    = 4'b1111;
        dm_wdata_o = mem_wdata_i;
        if (sz_b) begin
            dm_be_o    = 4'b0001 << byte_lane;
            dm_wdata_o = {4{mem_wdata_i[7:0]}};
        end else if (sz_h) begin
            dm_be_o    = 4'b0011 << {byte_lane[1], 1'b0};
            dm_wdata_o = {2{mem_wdata_i[15:0]}};
        end
    end

    assign issue   = valid_i && is_mem && !misalign && !(is_sc && !llbit);
    assign tmo_hit = (state == S_WAIT) && (cnt == CW'(TIMEOUT));

    always_comb begin
        state_nx = state;
        req      = 1'b0;
        case (state)
            S_IDLE: if (issue) begin
                req = 1'b1;
                if (!dm_ack_i) state_nx = S_WAIT;
            end
            S_WAIT: begin
                // A late ack in the timeout cycle still wins.
                if (dm_ack_i) begin
                    req      = 1'b1;
                    state_nx = S_IDLE;
                end else if (tmo_hit) begin
                    state_nx = S_IDLE;
                end else begin
                    req = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        if (!rst) req = 1'b0;
    end

    assign done        = req && dm_ack_i;
    assign timeout     = rst && tmo_hit && !dm_ack_i;
    assign dm_req_o    = req;
    assign dm_we_o     = req && is_store;
    assign stall_req_o = req && !dm_ack_i;
    assign fire        = ((state == S_IDLE) && valid_i && !issue) || done || timeout;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            llbit      <= 1'b0;
            valid_o    <= 1'b0;
            wd_o       <= '0;
            wreg_o     <= 1'b0;
            wdata_o    <= '0;
            whilo_o    <= 1'b0;
            hi_o       <= '0;
            lo_o       <= '0;
            adel_o     <= 1'b0;
            ades_o     <= 1'b0;
            buserr_o   <= 1'b0;
            badvaddr_o <= '0;
        end else begin
            state <= state_nx;
            if (state_nx == S_WAIT) cnt <= (state == S_IDLE) ? CW'(1) : cnt + CW'(1);
            else                    cnt <= '0;

            if (llbit_clr_i)        llbit <= 1'b0;
            else if (done && is_ll) llbit <= 1'b1;

            valid_o  <= 1'b0;
            adel_o   <= 1'b0;
            ades_o   <= 1'b0;
            buserr_o <= 1'b0;
            if (fire) begin
                valid_o <= 1'b1;
                wd_o    <= wd_i;
                wreg_o  <= wreg_i;
                wdata_o <= wdata_i;
                whilo_o <= whilo_i;
                hi_o    <= hi_i;
                lo_o    <= lo_i;
                if (timeout) begin
                    wreg_o     <= 1'b0;
                    whilo_o    <= 1'b0;
                    buserr_o   <= 1'b1;
                    badvaddr_o <= mem_addr_i;
                end else if (is_mem && misalign) begin
                    wreg_o     <= 1'b0;
                    whilo_o    <= 1'b0;
                    adel_o     <= is_load;
                    ades_o     <= is_store;
                    badvaddr_o <= mem_addr_i;
                end else if (done) begin
                    wdata_o <= res;
                end else if (is_sc) begin
                    wdata_o <= 32'd0;
                end
            end
        end
    end
endmodule

// File: doc/mem_lsu_stage.md
# mem_lsu_stage

Pipelined MEM stage for the MIPS32 core. It replaces the pass-through memory stage with a stage that performs loads and stores over a request/acknowledge data-memory port and stalls the pipeline while an access is outstanding. It also handles byte-lane alignment and sign/zero extension, checks address alignment, tracks the LL/SC link bit and enforces a bus timeout. It sits between the EX/MEM and MEM/WB pipeline registers, and its outputs are registered.

## Interface
- REG_AW, 5, register-file address width
- TIMEOUT, 15, maximum WAIT cycles before bus error (≥1)
- BIG_ENDIAN, 1, 1 = byte 0 on [31:24], 0 = byte 0 on [7:0]
- ALIGN_CHECK, 1, 1 = raise address errors on misaligned half/word access, 0 = force-align (clear low address bits)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-low
- valid_i  in  1  EX/MEM holds a valid instruction
- wd_i / wreg_i / wdata_i  in  REG_AW/1/32  destination, write enable, ALU result
- whilo_i / hi_i / lo_i  in  1/32/32  HI/LO write enable and values
- mem_op_i  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, 9 LL, 10 SC; 11–15 treated as NONE
- mem_addr_i / mem_wdata_i  in  32/32  effective address, store data (rt)
- llbit_clr_i  in  1  clears link bit (ERET/exception)
- dm_req_o / dm_we_o  out  1/1  access request, write
- dm_addr_o / dm_be_o / dm_wdata_o  out  32/4/32  word address (low 2 bits 0), byte enables, lane-replicated store data
- dm_ack_i / dm_rdata_i  in  1/32  access complete, read word
- stall_req_o  out  1  hold upstream stages
- valid_o / wd_o / wreg_o / wdata_o  out  1/REG_AW/1/32  registered result to MEM/WB
- whilo_o / hi_o / lo_o  out  1/32/32  registered HI/LO write
- adel_o / ades_o / buserr_o / badvaddr_o  out  1/1/1/32  one-cycle exception pulses, faulting address

## Operation
- FSM: IDLE, WAIT.
- IDLE, valid_i=0: valid_o←0 next edge.
- IDLE, NONE op: all inputs are registered to outputs, with valid_o←1.
- IDLE, memory op, misaligned (LH/LHU/SH: addr[0]≠0; LW/SW/LL/SC: addr[1:0]≠0) with ALIGN_CHECK=1:
  - no request
  - valid_o←1, wreg_o←0, whilo_o←0
  - adel_o (loads/LL) or ades_o (stores/SC) ←1; badvaddr_o←addr
- IDLE, SC with llbit=0: no request; valid_o←1, wdata_o←0, wreg_o←wreg_i.
- IDLE, other memory op:
  - dm_req_o=1, stall_req_o=1 combinationally
  - if dm_ack_i is also 1 this cycle, the access completes now; otherwise go to WAIT
- WAIT: dm_req_o=1 and stall_req_o=1 until dm_ack_i. Timeout counter increments each WAIT cycle.
- Completion (ack):
  - stall_req_o=0 that cycle; register result, valid_o←1, return to IDLE
  - Loads: select lane by addr[1:0] and BIG_ENDIAN; LB/LH sign-extend, LBU/LHU zero-extend
  - LL: sets llbit←1
  - SC: wdata_o←1
  - Stores: wdata_o←wdata_i
- Timeout: counter reaches TIMEOUT without ack → dm_req_o=0, stall_req_o=0 that cycle; valid_o←1, wreg_o←0, buserr_o←1, badvaddr_o←addr; return to IDLE.
- Byte enables: SB one bit, SH two bits, SW/SC 4'b1111. Lane mapping: BIG_ENDIAN=1 offset 0→be[3]; BIG_ENDIAN=0 offset 0→be[0].
- Store data replicated: byte ×4, half ×2.
- llbit: llbit_clr_i has priority over LL set in the same cycle.
- Upstream holds all *_i stable while stall_req_o=1.

## Timing
- Reset (rst=0 at edge):
  - state IDLE, counter 0, llbit 0
  - all registered outputs 0
  - dm_req_o, dm_we_o, stall_req_o forced 0 while rst=0, including mid-WAIT
- Latency:
  - NONE/fault: result 1 cycle after valid_i
  - memory op: result on the edge of the ack cycle
  - zero-wait ack: no stall edge
  - ack after N wait cycles: N stall cycles
- Exception and buserr pulses last exactly one cycle, aligned with valid_o.
- An ack arriving in the same cycle the counter reaches TIMEOUT counts as success.

## Test plan
- NONE op, wd_i=5'd3, wdata_i=32'h1234, whilo_i=1, hi_i=1, lo_i=2 → one edge later valid_o=1, wd_o=3, wdata_o=32'h1234, hi_o=1, lo_o=2, stall_req_o never high.
- LB addr=32'h1001, BIG_ENDIAN=1, dm_rdata_i=32'h11_82_33_44, ack after 2 cycles → dm_addr_o=32'h1000, 2 stall cycles, wdata_o=32'hFFFFFF82; repeat LBU → 32'h00000082.
- SH addr=32'h2002, mem_wdata_i=32'hxxxxBEEF → dm_be_o=4'b0011, dm_wdata_o=32'hBEEFBEEF, dm_we_o=1; SW addr=32'h2002 → ades_o=1, badvaddr_o=32'h2002, dm_req_o stays 0.
- LL addr=32'h3000 acked; then SC → store issued, wdata_o=1. Then llbit_clr_i; SC → no request, wdata_o=0.
- LW, dm_ack_i held 0, TIMEOUT=15 → 15 stall cycles, then buserr_o=1, wreg_o=0, dm_req_o drops; ack on the 15th cycle instead → normal load.
- rst=0 asserted during WAIT → next cycle dm_req_o=0, stall_req_o=0, valid_o=0, llbit=0; first op after release behaves normally.
